// File: rtl/usb1bd_reg_mep.sv
// Register block for a multi-endpoint USB 1.1 device core: configuration, sticky
// interrupt status, endpoint FIFO windows, token capture and a saturating error counter.
module usb1bd_reg_mep #(
   parameter int NUM_EP = 4,
   parameter int OCC_W  = 5
) (
   input  logic                    mclk,
   input  logic                    reset_n,
   input  logic                    reg_cs,
   input  logic                    reg_wr,
   input  logic [3:0]              reg_addr,
   input  logic [31:0]             reg_wdata,
   input  logic [3:0]              reg_be,
   output logic [31:0]             reg_rdata,
   output logic                    reg_ack,
   output logic                    cfg_usb_enb,
   output logic                    usb_srst_n,
   output logic [7:0]              cfg_max_hms,
   input  logic                    rx_token_valid,
   input  logic [6:0]              rx_token_fadr,
   input  logic [3:0]              rx_ep_sel,
   input  logic                    usb_rst,
   input  logic                    pid_cs_err,
   input  logic                    crc5_err,
   input  logic                    crc16_err,
   input  logic [31:0]             frm_nat,
   output logic [NUM_EP-1:0]       tx_fifo_wr_en,
   output logic [7:0]              tx_fifo_data,
   input  logic [NUM_EP-1:0]       tx_fifo_full,
   input  logic [NUM_EP-1:0]       tx_fifo_empty,
   input  logic [NUM_EP*OCC_W-1:0] tx_fifo_occ,
   output logic [NUM_EP-1:0]       rx_fifo_rd_en,
   input  logic [NUM_EP*8-1:0]     rx_fifo_data,
   input  logic [NUM_EP-1:0]       rx_fifo_empty,
   input  logic [NUM_EP-1:0]       rx_fifo_full,
   input  logic [NUM_EP*OCC_W-1:0] rx_fifo_occ,
   output logic                    usb_irq
);

   localparam logic [3:0]  A_CFG = 4'h0, A_STS = 4'h1, A_MSK = 4'h2, A_FRM = 4'h3, A_SEL = 4'h4;
   localparam logic [3:0]  A_EPS = 4'h5, A_TXW = 4'h6, A_RXR = 4'h7, A_TOK = 4'h8, A_ERR = 4'h9;
   localparam logic [31:0] CFG_MASK = 32'h00FF_0003;

   logic              r_ack;
   logic [31:0]       r_rdata;
   logic [31:0]       r_cfg;
   logic [31:0]       r_sts;
   logic [31:0]       r_mask;
   logic [3:0]        r_sel;
   logic [31:0]       r_tok;
   logic [7:0]        r_errcnt;
   logic              r_irq;
   logic [NUM_EP-1:0] r_rx_empty_d;

   logic [15:0]       w_txf, w_txe, w_rxf, w_rxe, w_wr16, w_rd16;
   logic [7:0]        w_rxd [16];
   logic [OCC_W-1:0]  w_txo [16];
   logic [OCC_W-1:0]  w_rxo [16];
   logic              w_start, w_wacc, w_racc;
   logic              w_tx_push, w_tx_ovf, w_rx_pop, w_rx_und;
   logic [31:0]       w_bemask, w_rd, w_set, w_clr;
   logic [1:0]        w_err_n;
   logic [7:0]        w_cnt_nxt;
   logic              w_sat_set;
   logic [NUM_EP-1:0] w_ne_edge;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {7'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   // Endpoint-indexed views padded to 16 entries so the 4-bit select indexes them directly.
   always_comb begin
      w_txf = '0;
      w_txe = '0;
      w_rxf = '0;
      w_rxe = '0;
      for (int n = 0; n < 16; n++) begin
         w_rxd[n] = '0;
         w_txo[n] = '0;
         w_rxo[n] = '0;
      end
      for (int n = 0; n < NUM_EP; n++) begin
         w_txf[n] = tx_fifo_full[n];
         w_txe[n] = tx_fifo_empty[n];
         w_rxf[n] = rx_fifo_full[n];
         w_rxe[n] = rx_fifo_empty[n];
         w_rxd[n] = rx_fifo_data[n*8 +: 8];
         w_txo[n] = tx_fifo_occ[n*OCC_W +: OCC_W];
         w_rxo[n] = rx_fifo_occ[n*OCC_W +: OCC_W];
      end
   end

   assign w_start  = reg_cs & ~r_ack;
   assign w_wacc   = reg_cs & r_ack & reg_wr;
   assign w_racc   = reg_cs & r_ack & ~reg_wr;
   assign w_bemask = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};

   assign w_tx_push = w_wacc & (reg_addr == A_TXW) & reg_be[0] & ~w_txf[r_sel];
   assign w_tx_ovf  = w_wacc & (reg_addr == A_TXW) & reg_be[0] & w_txf[r_sel];
   assign w_rx_pop  = w_racc & (reg_addr == A_RXR) & ~w_rxe[r_sel];
   assign w_rx_und  = w_racc & (reg_addr == A_RXR) & w_rxe[r_sel];

   always_comb begin
      w_wr16 = '0;
      w_rd16 = '0;
      w_wr16[r_sel] = w_tx_push;
      w_rd16[r_sel] = w_rx_pop;
   end

   assign tx_fifo_wr_en = w_wr16[NUM_EP-1:0];
   assign rx_fifo_rd_en = w_rd16[NUM_EP-1:0];
   assign tx_fifo_data  = reg_wdata[7:0];

   // A read of the counter restarts it from this cycle's errors so none are lost.
   assign w_err_n   = {1'b0, pid_cs_err} + {1'b0, crc5_err} + {1'b0, crc16_err};
   assign w_cnt_nxt = (w_racc && reg_addr == A_ERR) ? {6'b0, w_err_n} : sat_add8(r_errcnt, w_err_n);
   assign w_sat_set = (w_cnt_nxt == 8'hFF) && (r_errcnt != 8'hFF);
   assign w_ne_edge = r_rx_empty_d & ~rx_fifo_empty;

   always_comb begin
      w_set = '0;
      w_set[0] = usb_rst;
      w_set[1] = rx_token_valid;
      w_set[2] = pid_cs_err;
      w_set[3] = crc5_err;
      w_set[4] = crc16_err;
      w_set[5] = w_tx_ovf;
      w_set[6] = w_rx_und;
      w_set[7] = w_sat_set;
      w_set[16 +: NUM_EP] = w_ne_edge;
      w_clr = (w_wacc && reg_addr == A_STS) ? (reg_wdata & w_bemask) : 32'h0;
   end

   always_comb begin
      w_rd = '0;
      case (reg_addr)
         A_CFG: w_rd = r_cfg;
         A_STS: w_rd = r_sts;
         A_MSK: w_rd = r_mask;
         A_FRM: w_rd = frm_nat;
         A_SEL: w_rd[3:0] = r_sel;
         A_EPS: begin
            w_rd[3:0]          = {w_rxe[r_sel], w_rxf[r_sel], w_txe[r_sel], w_txf[r_sel]};
            w_rd[8 +: OCC_W]   = w_txo[r_sel];
            w_rd[16 +: OCC_W]  = w_rxo[r_sel];
         end
         A_RXR: w_rd[7:0] = w_rxe[r_sel] ? 8'h00 : w_rxd[r_sel];
         A_TOK: w_rd = r_tok;
         A_ERR: w_rd[7:0] = r_errcnt;
         default: w_rd = '0;
      endcase
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         r_ack        <= 1'b0;
         r_rdata      <= '0;
         r_cfg        <= '0;
         r_sts        <= '0;
         r_mask       <= '0;
         r_sel        <= '0;
         r_tok        <= '0;
         r_errcnt     <= '0;
         r_irq        <= 1'b0;
         r_rx_empty_d <= '1;
      end else begin
         r_ack        <= w_start;
         r_errcnt     <= w_cnt_nxt;
         r_rx_empty_d <= rx_fifo_empty;
         r_irq        <= |(r_sts & r_mask);
         r_sts        <= (r_sts & ~w_clr) | w_set;
         if (w_start && !reg_wr)
            r_rdata <= w_rd;
         if (w_wacc && reg_addr == A_CFG)
            r_cfg <= ((r_cfg & ~w_bemask) | (reg_wdata & w_bemask)) & CFG_MASK;
         if (w_wacc && reg_addr == A_MSK)
            r_mask <= (r_mask & ~w_bemask) | (reg_wdata & w_bemask);
         // Out-of-range endpoint numbers are dropped so the select always names a real EP.
         if (w_wacc && reg_addr == A_SEL && reg_be[0] && ({1'b0, reg_wdata[3:0]} < 5'(NUM_EP)))
            r_sel <= reg_wdata[3:0];
         if (rx_token_valid)
            r_tok <= {1'b1, 20'h0, rx_token_fadr, rx_ep_sel};
         else if (w_racc && reg_addr == A_TOK)
            r_tok[31] <= 1'b0;
      end
   end

   assign reg_ack     = r_ack;
   assign reg_rdata   = r_rdata;
   assign usb_irq     = r_irq;
   assign cfg_usb_enb = r_cfg[0];
   assign usb_srst_n  = ~r_cfg[1];
   assign cfg_max_hms = r_cfg[23:16];

endmodule

// File: tb/tb_usb1bd_reg_mep.sv
// Randomized bench for usb1bd_reg_mep against a transaction-level model of the
// register map, FIFO windows, sticky status and error counter.
module tb_usb1bd_reg_mep;

   localparam int P = 4;
   localparam int O = 5;

   logic          mclk = 1'b0;
   logic          reset_n = 1'b0;
   logic          reg_cs = 1'b0, reg_wr = 1'b0;
   logic [3:0]    reg_addr = '0;
   logic [31:0]   reg_wdata = '0;
   logic [3:0]    reg_be = '0;
   logic [31:0]   reg_rdata;
   logic          reg_ack;
   logic          cfg_usb_enb, usb_srst_n;
   logic [7:0]    cfg_max_hms;
   logic          rx_token_valid = 1'b0;
   logic [6:0]    rx_token_fadr = '0;
   logic [3:0]    rx_ep_sel = '0;
   logic          usb_rst = 1'b0, pid_cs_err = 1'b0, crc5_err = 1'b0, crc16_err = 1'b0;
   logic [31:0]   frm_nat = '0;
   logic [P-1:0]  tx_fifo_wr_en;
   logic [7:0]    tx_fifo_data;
   logic [P-1:0]  tx_fifo_full = '0, tx_fifo_empty = '1;
   logic [P*O-1:0] tx_fifo_occ = '0;
   logic [P-1:0]  rx_fifo_rd_en;
   logic [P*8-1:0] rx_fifo_data = '0;
   logic [P-1:0]  rx_fifo_empty = '1, rx_fifo_full = '0;
   logic [P*O-1:0] rx_fifo_occ = '0;
   logic          usb_irq;

   usb1bd_reg_mep #(.NUM_EP(P), .OCC_W(O)) dut (
      .mclk(mclk), .reset_n(reset_n),
      .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
      .cfg_usb_enb(cfg_usb_enb), .usb_srst_n(usb_srst_n), .cfg_max_hms(cfg_max_hms),
      .rx_token_valid(rx_token_valid), .rx_token_fadr(rx_token_fadr), .rx_ep_sel(rx_ep_sel),
      .usb_rst(usb_rst), .pid_cs_err(pid_cs_err), .crc5_err(crc5_err), .crc16_err(crc16_err),
      .frm_nat(frm_nat),
      .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_data(tx_fifo_data), .tx_fifo_full(tx_fifo_full),
      .tx_fifo_empty(tx_fifo_empty), .tx_fifo_occ(tx_fifo_occ),
      .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_data(rx_fifo_data), .rx_fifo_empty(rx_fifo_empty),
      .rx_fifo_full(rx_fifo_full), .rx_fifo_occ(rx_fifo_occ),
      .usb_irq(usb_irq)
   );

   always #5 mclk = ~mclk;

   int cyc = 0;
   always @(posedge mclk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   // model state
   logic [31:0] m_cfg = '0, m_sts = '0, m_mask = '0, m_tok = '0;
   int          m_sel = 0;
   int          m_cnt = 0;
   logic [P-1:0] m_empty = '1;

   // observations captured by the bus task
   logic [P-1:0] g_wr_en, g_rd_en, g_wr_en2, g_rd_en2;
   logic [7:0]   g_txd;
   logic [2:0]   g_hook = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic bus(input logic wr, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rdv);
      int lat;
      lat = 0;
      reg_cs = 1'b1; reg_wr = wr; reg_addr = a; reg_wdata = d; reg_be = be;
      do begin
         tick();
         lat++;
      end while (!reg_ack && lat < 8);
      chk("ack_lat", 32'(lat), 32'd1);
      rdv      = reg_rdata;
      g_wr_en  = tx_fifo_wr_en;
      g_rd_en  = rx_fifo_rd_en;
      g_txd    = tx_fifo_data;
      usb_rst        = g_hook[0];
      pid_cs_err     = g_hook[1];
      rx_token_valid = g_hook[2];
      tick();
      chk("ack_pulse", {31'b0, reg_ack}, 32'd0);
      g_wr_en2 = tx_fifo_wr_en;
      g_rd_en2 = rx_fifo_rd_en;
      usb_rst = 1'b0; pid_cs_err = 1'b0; rx_token_valid = 1'b0;
      g_hook = '0;
      reg_cs = 1'b0; reg_wr = 1'b0;
   endtask

   task automatic do_rd(input logic [3:0] a, output logic [31:0] d);
      bus(1'b0, a, 32'h0, 4'hF, d);
   endtask

   task automatic do_wr(input logic [3:0] a, input logic [31:0] d);
      logic [31:0] x;
      bus(1'b1, a, d, 4'hF, x);
   endtask

   task automatic set_rx_empty(input logic [P-1:0] v);
      rx_fifo_empty = v;
      tick();
      m_sts = m_sts | (32'(m_empty & ~v) << 16);
      m_empty = v;
   endtask

   function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic model_err(input int s);
      int prev;
      prev  = m_cnt;
      m_cnt = (m_cnt + s > 255) ? 255 : m_cnt + s;
      if (prev < 255 && m_cnt == 255) m_sts[7] = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] r, d, e;
      logic [3:0]  be;
      logic [P-1:0] em;
      logic [6:0]  fa;
      logic [3:0]  ep;
      int          c0, s, v;

      // reset state
      repeat (3) tick();
      chk("rst_ack", {31'b0, reg_ack}, 32'd0);
      chk("rst_rdata", reg_rdata, 32'd0);
      chk("rst_irq", {31'b0, usb_irq}, 32'd0);
      chk("rst_srst_n", {31'b0, usb_srst_n}, 32'd1);
      chk("rst_enb", {31'b0, cfg_usb_enb}, 32'd0);
      chk("rst_hms", {24'b0, cfg_max_hms}, 32'd0);
      chk("rst_wr_en", 32'(tx_fifo_wr_en), 32'd0);
      chk("rst_rd_en", 32'(rx_fifo_rd_en), 32'd0);
      reset_n = 1'b1;
      tick();
      foreach (r[i]) ; // keep r declared use simple
      do_rd(4'h0, r); chk("rst_reg0", r, 32'h0);
      do_rd(4'h1, r); chk("rst_reg1", r, 32'h0);
      do_rd(4'h2, r); chk("rst_reg2", r, 32'h0);
      do_rd(4'h4, r); chk("rst_reg4", r, 32'h0);
      do_rd(4'h8, r); chk("rst_reg8", r, 32'h0);
      do_rd(4'h9, r); chk("rst_reg9", r, 32'h0);

      // configuration register, back-to-back timing
      c0 = cyc;
      do_wr(4'h0, 32'h0012_0003);
      do_rd(4'h0, r);
      chk("b2b_cycles", 32'(cyc - c0), 32'd4);
      m_cfg = 32'h0012_0003;
      chk("reg0_rb", r, 32'h0012_0003);
      chk("hms", {24'b0, cfg_max_hms}, 32'h12);
      chk("srst_n", {31'b0, usb_srst_n}, 32'd0);
      chk("enb", {31'b0, cfg_usb_enb}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         d  = $urandom;
         be = 4'($urandom_range(0, 15));
         bus(1'b1, 4'h0, d, be, r);
         m_cfg = bmerge(m_cfg, d, be) & 32'h00FF_0003;
         do_rd(4'h0, r);
         chk("reg0_rand", r, m_cfg);
         chk("srst_rand", {31'b0, usb_srst_n}, {31'b0, ~m_cfg[1]});
      end

      // unmapped addresses
      for (int a = 10; a < 16; a++) begin
         do_wr(4'(a), $urandom);
         do_rd(4'(a), r);
         chk("unmapped", r, 32'h0);
      end
      do_rd(4'h0, r); chk("reg0_after_unmapped", r, m_cfg);

      frm_nat = $urandom;
      do_rd(4'h3, r); chk("frm_nat", r, frm_nat);

      // endpoint select
      do_wr(4'h4, 32'h2); do_rd(4'h4, r); chk("sel_2", r, 32'h2);
      do_wr(4'h4, 32'h7); do_rd(4'h4, r); chk("sel_7_ignored", r, 32'h2);
      m_sel = 2;
      for (int i = 0; i < 6; i++) begin
         v = $urandom_range(0, 15);
         do_wr(4'h4, 32'(v));
         if (v < P) m_sel = v;
         do_rd(4'h4, r); chk("sel_rand", r, 32'(m_sel));
      end

      // endpoint status window
      for (int i = 0; i < 4; i++) begin
         s = $urandom_range(0, P-1);
         do_wr(4'h4, 32'(s)); m_sel = s;
         tx_fifo_full  = 4'($urandom); tx_fifo_empty = 4'($urandom);
         rx_fifo_full  = 4'($urandom);
         tx_fifo_occ   = 20'($urandom); rx_fifo_occ = 20'($urandom);
         set_rx_empty(4'($urandom));
         e = '0;
         e[3:0]   = {m_empty[s], rx_fifo_full[s], tx_fifo_empty[s], tx_fifo_full[s]};
         e[12:8]  = tx_fifo_occ[s*O +: O];
         e[20:16] = rx_fifo_occ[s*O +: O];
         do_rd(4'h5, r); chk("ep_status", r, e);
      end

      // TX push window
      do_wr(4'h4, 32'h2); m_sel = 2;
      tx_fifo_full = 4'b0000;
      do_wr(4'h6, 32'h0000_00A5);
      chk("tx_push_en", 32'(g_wr_en), 32'h4);
      chk("tx_push_data", {24'b0, g_txd}, 32'hA5);
      chk("tx_push_1cyc", 32'(g_wr_en2), 32'h0);
      tx_fifo_full = 4'b0100;
      do_wr(4'h6, 32'h0000_005A);
      chk("tx_full_no_push", 32'(g_wr_en), 32'h0);
      m_sts[5] = 1'b1;
      do_rd(4'h1, r); chk("tx_ovf_sts", r, m_sts);
      for (int i = 0; i < 4; i++) begin
         s = $urandom_range(0, P-1);
         do_wr(4'h4, 32'(s)); m_sel = s;
         tx_fifo_full = 4'($urandom);
         d = $urandom;
         do_wr(4'h6, d);
         chk("tx_rand_en", 32'(g_wr_en), tx_fifo_full[s] ? 32'h0 : (32'h1 << s));
         if (!tx_fifo_full[s]) chk("tx_rand_data", {24'b0, g_txd}, {24'b0, d[7:0]});
         else m_sts[5] = 1'b1;
      end
      do_rd(4'h6, r); chk("reg6_read0", r, 32'h0);
      tx_fifo_full = '0;

      // RX pop window
      for (int i = 0; i < 6; i++) begin
         s = $urandom_range(0, P-1);
         do_wr(4'h4, 32'(s)); m_sel = s;
         rx_fifo_data = $urandom;
         em = 4'($urandom);
         set_rx_empty(em);
         do_rd(4'h7, r);
         chk("rx_data", r, em[s] ? 32'h0 : {24'b0, rx_fifo_data[s*8 +: 8]});
         chk("rx_pop_en", 32'(g_rd_en), em[s] ? 32'h0 : (32'h1 << s));
         chk("rx_pop_1cyc", 32'(g_rd_en2), 32'h0);
         if (em[s]) m_sts[6] = 1'b1;
      end
      do_wr(4'h7, 32'hFF);
      chk("rx_write_no_pop", 32'(g_rd_en), 32'h0);
      do_rd(4'h1, r); chk("sts_after_fifo", r, m_sts);

      // non-empty interrupt and mask
      set_rx_empty(4'hF);
      do_wr(4'h1, 32'hFFFF_FFFF); m_sts = '0;
      do_rd(4'h1, r); chk("sts_cleared", r, 32'h0);
      set_rx_empty(4'b1011);
      do_rd(4'h1, r); chk("rx_ne_bit18", r, 32'h0004_0000);
      chk("irq_unmasked", {31'b0, usb_irq}, 32'd0);
      do_wr(4'h2, 32'h0004_0000); m_mask = 32'h0004_0000;
      chk("irq_not_yet", {31'b0, usb_irq}, 32'd0);
      tick();
      chk("irq_set", {31'b0, usb_irq}, 32'd1);
      do_wr(4'h1, 32'h0004_0000); m_sts[18] = 1'b0;
      tick();
      chk("irq_clr", {31'b0, usb_irq}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         set_rx_empty(4'($urandom));
         m_mask = $urandom;
         do_wr(4'h2, m_mask);
         tick();
         chk("irq_rand", {31'b0, usb_irq}, {31'b0, |(m_sts & m_mask)});
      end
      do_wr(4'h2, 32'h0); m_mask = '0;

      // token capture
      for (int i = 0; i < 3; i++) begin
         fa = 7'($urandom); ep = 4'($urandom);
         rx_token_fadr = fa; rx_ep_sel = ep; rx_token_valid = 1'b1;
         tick();
         rx_token_valid = 1'b0;
         m_tok = {1'b1, 20'h0, fa, ep}; m_sts[1] = 1'b1;
         do_rd(4'h8, r); chk("tok_cap", r, m_tok);
         m_tok[31] = 1'b0;
         do_rd(4'h8, r); chk("tok_rdclr", r, m_tok);
      end
      fa = 7'($urandom); ep = 4'($urandom);
      rx_token_fadr = fa; rx_ep_sel = ep; g_hook = 3'b100;
      do_rd(4'h8, r); chk("tok_race_old", r, m_tok);
      m_tok = {1'b1, 20'h0, fa, ep};
      do_rd(4'h8, r); chk("tok_race_new", r, m_tok);
      do_rd(4'h1, r); chk("sts_tok", r, m_sts);

      // error counter
      do_wr(4'h1, 32'hFFFF_FFFF); m_sts = '0;
      for (int i = 0; i < 20; i++) begin
         v = $urandom_range(0, 7);
         pid_cs_err = v[0]; crc5_err = v[1]; crc16_err = v[2];
         tick();
         model_err(v[0] + v[1] + v[2]);
         m_sts[4:2] = m_sts[4:2] | 3'(v);
      end
      pid_cs_err = 1'b0; crc5_err = 1'b0; crc16_err = 1'b0;
      do_rd(4'h9, r); chk("errcnt_rand", r, 32'(m_cnt));
      m_cnt = 0;
      do_rd(4'h1, r); chk("sts_err_rand", r, m_sts);
      crc5_err = 1'b1; crc16_err = 1'b1;
      for (int i = 0; i < 128; i++) begin
         tick();
         model_err(2);
      end
      crc5_err = 1'b0; crc16_err = 1'b0;
      m_sts[4:3] = 2'b11;
      do_rd(4'h1, r); chk("sts_sat", r, m_sts);
      g_hook = 3'b010;
      do_rd(4'h9, r); chk("errcnt_255", r, 32'd255);
      m_cnt = 1; m_sts[2] = 1'b1;
      do_rd(4'h9, r); chk("errcnt_reload", r, 32'(m_cnt));
      m_cnt = 0;

      // hardware set wins over W1C
      usb_rst = 1'b1; tick(); usb_rst = 1'b0; m_sts[0] = 1'b1;
      g_hook = 3'b001;
      do_wr(4'h1, 32'h1);
      do_rd(4'h1, r); chk("w1c_race", r, m_sts);
      do_wr(4'h1, 32'h1); m_sts[0] = 1'b0;
      do_rd(4'h1, r); chk("w1c_plain", r, m_sts);

      // reset before the ack
      set_rx_empty(4'hF);
      do_wr(4'h4, 32'h2);
      tx_fifo_full = '0;
      reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 4'h6; reg_wdata = 32'h77; reg_be = 4'hF;
      #2 reset_n = 1'b0;
      tick();
      chk("rst_mid_ack", {31'b0, reg_ack}, 32'd0);
      chk("rst_mid_wr_en", 32'(tx_fifo_wr_en), 32'h0);
      reg_cs = 1'b0; reg_wr = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      do_rd(4'h0, r); chk("rst_mid_reg0", r, 32'h0);
      chk("rst_mid_srst", {31'b0, usb_srst_n}, 32'd1);

      // reset during the ack cycle
      reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 4'h6; reg_wdata = 32'h33; reg_be = 4'hF;
      tick();
      chk("ack_cyc_push", 32'(tx_fifo_wr_en), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_ack_cyc_ack", {31'b0, reg_ack}, 32'd0);
      chk("rst_ack_cyc_wr_en", 32'(tx_fifo_wr_en), 32'h0);
      reg_cs = 1'b0; reg_wr = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      do_rd(4'h1, r); chk("rst_ack_cyc_sts", r, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/usb1bd_reg_mep.md
USB1BD_REG_MEP -- requirements
Module: usb1bd_reg_mep

Interface
REQ-001 SHALL provide parameters: NUM_EP, default 4 (1..16), number of endpoint FIFO pairs; OCC_W, default 5, FIFO occupancy width.
REQ-002 SHALL have one clock (mclk) and an asynchronous active-low reset (reset_n).
REQ-003 SHALL provide these ports; P=NUM_EP, O=OCC_W:
- mclk  in  1  clock
- reset_n  in  1  async active-low reset
- reg_cs / reg_wr  in  1/1  access request / write
- reg_addr  in  4  word address
- reg_wdata  in  32  write data
- reg_be  in  4  byte enables
- reg_rdata  out  32  read data
- reg_ack  out  1  access acknowledge
- cfg_usb_enb / usb_srst_n  out  1/1  core enable / soft reset
- cfg_max_hms  out  8  max half-ms count
- rx_token_valid  in  1  token received pulse
- rx_token_fadr  in  7  token function address
- rx_ep_sel  in  4  token endpoint
- usb_rst / pid_cs_err / crc5_err / crc16_err  in  1 each  event pulses
- frm_nat  in  32  frame number/time
- tx_fifo_wr_en  out  P  per-EP push
- tx_fifo_data  out  8  push data, shared
- tx_fifo_full / tx_fifo_empty  in  P/P  per-EP flags
- tx_fifo_occ  in  P*O  per-EP occupancy
- rx_fifo_rd_en  out  P  per-EP pop
- rx_fifo_data  in  P*8  per-EP head data
- rx_fifo_empty / rx_fifo_full  in  P/P  per-EP flags
- rx_fifo_occ  in  P*O  per-EP occupancy
- usb_irq  out  1  level interrupt

Function
REQ-004 Handshake: reg_ack SHALL rise the cycle after reg_cs is sampled high with reg_ack low, stay high exactly 1 cycle, then go low even if reg_cs stays high; the master holds cs/wr/addr/wdata until ack, so back-to-back accesses complete every 2 cycles.
REQ-005 Read data SHALL be registered into reg_rdata together with the ack rise; unmapped addresses 0xA-0xF SHALL read 0 and ignore writes.
REQ-006 Write side effects SHALL occur in the ack-high cycle only, honouring reg_be per byte.
REQ-007 Reg0 (RW, reset 0x0000_0000): bit0 cfg_usb_enb; bit1 soft reset (usb_srst_n = !bit1); [23:16] cfg_max_hms.
REQ-008 Reg1 interrupt status (W1C): [0] usb_rst, [1] rx_token_valid, [2] pid_cs_err, [3] crc5_err, [4] crc16_err, [5] tx overflow, [6] rx underflow, [7] error counter saturated, [16+n] rx FIFO n went non-empty; bits for n>=NUM_EP and [15:8] SHALL read 0.
REQ-009 Status bits SHALL be sticky and set on the event; the non-empty event is a 1->0 edge of rx_fifo_empty[n] against a registered copy that resets to all-ones; a hardware set and a W1C of the same bit in the same cycle SHALL leave the bit set.
REQ-010 Reg2 interrupt mask (RW, reset 0); usb_irq SHALL be registered: usb_irq = |(reg1 & reg2), one cycle after either changes.
REQ-011 Reg3 (RO) SHALL return frm_nat.
REQ-012 Reg4 EP select (RW [3:0], reset 0): a write of a value >= NUM_EP SHALL be ignored and the old value kept.
REQ-013 Reg5 (RO) SHALL return the status of the selected EP s: [3:0] {rx_empty, rx_full, tx_empty, tx_full}[s]; [8+:O] tx_occ[s]; [16+:O] rx_occ[s].
REQ-014 Reg6 TX write: in the ack cycle, tx_fifo_wr_en[s] = 1 with tx_fifo_data = wdata[7:0] if !tx_fifo_full[s]; otherwise no push and status[5] is set; reads return 0.
REQ-015 Reg7 RX read: reg_rdata[7:0] = rx_fifo_data[s] (0 if empty); rx_fifo_rd_en[s] SHALL pulse in the ack cycle if !rx_fifo_empty[s], otherwise status[6] is set; writes are ignored.
REQ-016 Only one bit of tx_fifo_wr_en/rx_fifo_rd_en SHALL be high at a time, for 1 cycle per access.
REQ-017 Reg8 token capture (RO, reset 0) SHALL load on rx_token_valid: [3:0] rx_ep_sel, [10:4] rx_token_fadr, [31] set; [31] SHALL clear on the ack cycle of a read of reg8 unless a new token arrives in that cycle.
REQ-018 Reg9 error counter (RO, 8 bits): SHALL add the count of pid_cs_err+crc5_err+crc16_err (0..3) each cycle and saturate at 255; status[7] is set when it reaches 255; a read clears it in the ack cycle, loading that cycle's error count instead of 0.

Reset
REQ-019 On reset_n low, all registers, reg_rdata, reg_ack, usb_irq, tx_fifo_wr_en and rx_fifo_rd_en SHALL be 0, usb_srst_n 1, and the empty-edge history all-ones; reset mid-access SHALL abort it with no FIFO strobe.

Verification
REQ-020 Write reg0=0x0012_0003, read it back -> 0x0012_0003, cfg_max_hms=0x12, usb_srst_n=0; ack is a 1-cycle pulse, 2 cycles per access.
REQ-021 NUM_EP=4, reg4=2, write reg6=0xA5 with tx_full[2]=0 -> tx_fifo_wr_en=4'b0100 for 1 cycle, data 0xA5; repeat with full -> no strobe, reg1[5]=1.
REQ-022 Write reg4=7 with NUM_EP=4 -> reg4 stays 2; rx_empty[2] 1->0 -> reg1[18]=1; with mask bit 18 set -> usb_irq=1 next cycle; W1C 0x0004_0000 -> irq 0.
REQ-023 Assert crc5_err and crc16_err together 128 cycles -> reg9=255, reg1[7]=1; read reg9 during a pid_cs_err pulse -> returns 255, next read 1.
REQ-024 Pulse usb_rst in the same cycle as a W1C of bit0 -> reg1[0] stays 1.
